// File: rtl/vtx_buffer_if.sv
// Vertex buffer bus: producer-side strobes/parameters/vertices in,
// head vertex plus its owning object's parameters and status out.
interface vtx_buffer_if #(
    parameter int AW = 3
);
    logic          iEnable;
    logic          iInitObj;
    logic          iInitVtx;
    logic [15:0]   iScaleX, iScaleY, iScaleZ;
    logic [15:0]   iTranslX, iTranslY, iTranslZ;
    logic [15:0]   iCosRoll, iCosPitch, iCosYaw;
    logic [15:0]   iSenRoll, iSenPitch, iSenYaw;
    logic [15:0]   iVertexX, iVertexY, iVertexZ;
    logic          iVtxReady;

    logic          oVtxValid;
    logic [15:0]   oVertexX, oVertexY, oVertexZ;
    logic [15:0]   oScaleX, oScaleY, oScaleZ;
    logic [15:0]   oTranslX, oTranslY, oTranslZ;
    logic [15:0]   oCosRoll, oCosPitch, oCosYaw;
    logic [15:0]   oSenRoll, oSenPitch, oSenYaw;
    logic [AW:0]   oCount;
    logic          oFull;
    logic          oOverflow;
    logic          oObjErr;

    modport master (
        output iEnable, iInitObj, iInitVtx,
        output iScaleX, iScaleY, iScaleZ, iTranslX, iTranslY, iTranslZ,
        output iCosRoll, iCosPitch, iCosYaw, iSenRoll, iSenPitch, iSenYaw,
        output iVertexX, iVertexY, iVertexZ, iVtxReady,
        input  oVtxValid, oVertexX, oVertexY, oVertexZ,
        input  oScaleX, oScaleY, oScaleZ, oTranslX, oTranslY, oTranslZ,
        input  oCosRoll, oCosPitch, oCosYaw, oSenRoll, oSenPitch, oSenYaw,
        input  oCount, oFull, oOverflow, oObjErr
    );

    modport slave (
        input  iEnable, iInitObj, iInitVtx,
        input  iScaleX, iScaleY, iScaleZ, iTranslX, iTranslY, iTranslZ,
        input  iCosRoll, iCosPitch, iCosYaw, iSenRoll, iSenPitch, iSenYaw,
        input  iVertexX, iVertexY, iVertexZ, iVtxReady,
        output oVtxValid, oVertexX, oVertexY, oVertexZ,
        output oScaleX, oScaleY, oScaleZ, oTranslX, oTranslY, oTranslZ,
        output oCosRoll, oCosPitch, oCosYaw, oSenRoll, oSenPitch, oSenYaw,
        output oCount, oFull, oOverflow, oObjErr
    );
endinterface

// File: rtl/vtx_buffer.sv
// Vertex FIFO (first-word-fall-through) with two ping-pong object
// parameter banks. Each entry carries a 1-bit tag naming the bank that
// holds the parameters of the object it belongs to, so at most two
// objects can be live in the buffer at once.
module vtx_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic         iClock,
    input  logic         iReset,
    vtx_buffer_if.slave  bus
);
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_tag;
    logic           r_overflow;
    logic           r_obj_err;
    logic [15:0]    r_bank [2][12];
    logic [15:0]    r_mem_x [DEPTH];
    logic [15:0]    r_mem_y [DEPTH];
    logic [15:0]    r_mem_z [DEPTH];
    logic           r_mem_tag [DEPTH];
    logic [15:0]    r_last_x, r_last_y, r_last_z;

    logic           w_valid;
    logic           w_full;
    logic           w_head_tag;
    logic           w_obj_req;
    logic           w_obj_block;
    logic           w_obj_acc;
    logic           w_tag_next;
    logic           w_push_req;
    logic           w_push;
    logic           w_pop;
    logic           w_out_bank;
    logic [15:0]    w_prm_in [12];

    assign w_prm_in[0]  = bus.iScaleX;
    assign w_prm_in[1]  = bus.iScaleY;
    assign w_prm_in[2]  = bus.iScaleZ;
    assign w_prm_in[3]  = bus.iTranslX;
    assign w_prm_in[4]  = bus.iTranslY;
    assign w_prm_in[5]  = bus.iTranslZ;
    assign w_prm_in[6]  = bus.iCosRoll;
    assign w_prm_in[7]  = bus.iCosPitch;
    assign w_prm_in[8]  = bus.iCosYaw;
    assign w_prm_in[9]  = bus.iSenRoll;
    assign w_prm_in[10] = bus.iSenPitch;
    assign w_prm_in[11] = bus.iSenYaw;

    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_head_tag = r_mem_tag[r_rd_ptr];

    // An object strobe would overwrite the bank still referenced by the
    // head entry when the head belongs to the older of two live objects.
    assign w_obj_req   = bus.iEnable & bus.iInitObj;
    assign w_obj_block = w_valid & (w_head_tag != r_tag);
    assign w_obj_acc   = w_obj_req & ~w_obj_block;
    assign w_tag_next  = w_obj_acc ? ~r_tag : r_tag;

    assign w_push_req = bus.iEnable & bus.iInitVtx;
    assign w_pop      = w_valid & bus.iVtxReady;
    assign w_push     = w_push_req & (~w_full | w_pop);

    // Pointers, occupancy, tag and sticky error flags
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tag      <= 1'b0;
            r_overflow <= 1'b0;
            r_obj_err  <= 1'b0;
        end else begin
            r_tag <= w_tag_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_obj_req & w_obj_block) begin
                r_obj_err <= 1'b1;
            end
        end
    end

    // Accepted object parameters land in the bank not currently being filled
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 12; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
        end else if (w_obj_acc) begin
            for (int i = 0; i < 12; i++) begin
                r_bank[~r_tag][i] <= w_prm_in[i];
            end
        end
    end

    // Vertex storage; contents are only meaningful between the pointers
    always_ff @(posedge iClock) begin
        if (w_push) begin
            r_mem_x[r_wr_ptr]   <= bus.iVertexX;
            r_mem_y[r_wr_ptr]   <= bus.iVertexY;
            r_mem_z[r_wr_ptr]   <= bus.iVertexZ;
            r_mem_tag[r_wr_ptr] <= w_tag_next;
        end
    end

    // Remember the most recently consumed head so the outputs stay stable when empty
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_last_x <= '0;
            r_last_y <= '0;
            r_last_z <= '0;
        end else if (w_pop) begin
            r_last_x <= r_mem_x[r_rd_ptr];
            r_last_y <= r_mem_y[r_rd_ptr];
            r_last_z <= r_mem_z[r_rd_ptr];
        end
    end

    assign w_out_bank = w_valid ? w_head_tag : r_tag;

    assign bus.oVtxValid = w_valid;
    assign bus.oVertexX  = w_valid ? r_mem_x[r_rd_ptr] : r_last_x;
    assign bus.oVertexY  = w_valid ? r_mem_y[r_rd_ptr] : r_last_y;
    assign bus.oVertexZ  = w_valid ? r_mem_z[r_rd_ptr] : r_last_z;
    assign bus.oScaleX   = r_bank[w_out_bank][0];
    assign bus.oScaleY   = r_bank[w_out_bank][1];
    assign bus.oScaleZ   = r_bank[w_out_bank][2];
    assign bus.oTranslX  = r_bank[w_out_bank][3];
    assign bus.oTranslY  = r_bank[w_out_bank][4];
    assign bus.oTranslZ  = r_bank[w_out_bank][5];
    assign bus.oCosRoll  = r_bank[w_out_bank][6];
    assign bus.oCosPitch = r_bank[w_out_bank][7];
    assign bus.oCosYaw   = r_bank[w_out_bank][8];
    assign bus.oSenRoll  = r_bank[w_out_bank][9];
    assign bus.oSenPitch = r_bank[w_out_bank][10];
    assign bus.oSenYaw   = r_bank[w_out_bank][11];
    assign bus.oCount    = r_count;
    assign bus.oFull     = w_full;
    assign bus.oOverflow = r_overflow;
    assign bus.oObjErr   = r_obj_err;
endmodule

// File: tb/tb_vtx_buffer.sv
// Bench for vtx_buffer: directed scenarios followed by random traffic,
// all checked against a queue-of-vertices model in which every entry
// carries its owning object's id and full parameter snapshot.
module tb_vtx_buffer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   step_no;

    vtx_buffer_if #(.AW(AW)) bus();

    vtx_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int unsigned  oid;
        logic [15:0]  x;
        logic [15:0]  y;
        logic [15:0]  z;
        logic [191:0] prm;
    } ent_t;

    ent_t         q[$];
    int unsigned  cur_oid;
    logic [191:0] cur_prm;
    logic         m_ovf;
    logic         m_err;
    logic [47:0]  m_last;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_oid = 0;
        cur_prm = '0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        m_last  = '0;
    endtask

    task automatic compare_all();
        logic [191:0] op;
        logic [191:0] ep;
        logic [47:0]  ev;
        op = {bus.oSenYaw, bus.oSenPitch, bus.oSenRoll, bus.oCosYaw, bus.oCosPitch, bus.oCosRoll,
              bus.oTranslZ, bus.oTranslY, bus.oTranslX, bus.oScaleZ, bus.oScaleY, bus.oScaleX};
        ep = (q.size() != 0) ? q[0].prm : cur_prm;
        ev = (q.size() != 0) ? {q[0].x, q[0].y, q[0].z} : m_last;
        check("valid",    192'(bus.oVtxValid), 192'(q.size() != 0));
        check("count",    192'(bus.oCount),    192'(q.size()));
        check("full",     192'(bus.oFull),     192'(q.size() == DEPTH));
        check("overflow", 192'(bus.oOverflow), 192'(m_ovf));
        check("objerr",   192'(bus.oObjErr),   192'(m_err));
        check("vertex",   192'({bus.oVertexX, bus.oVertexY, bus.oVertexZ}), 192'(ev));
        check("params",   op, ep);
    endtask

    task automatic model_update(input logic en, input logic obj, input logic vtx, input logic rdy,
                                input logic [191:0] prm, input logic [15:0] x, input logic [15:0] y,
                                input logic [15:0] z);
        bit   pop;
        bit   full_pre;
        ent_t h;
        pop      = (q.size() != 0) && rdy;
        full_pre = (q.size() == DEPTH);
        if (en && obj) begin
            if (q.size() != 0 && q[0].oid != cur_oid) begin
                m_err = 1'b1;
            end else begin
                cur_oid++;
                cur_prm = prm;
            end
        end
        if (pop) begin
            h = q.pop_front();
            m_last = {h.x, h.y, h.z};
        end
        if (en && vtx) begin
            if (full_pre && !pop) begin
                m_ovf = 1'b1;
            end else begin
                h.oid = cur_oid;
                h.x = x;
                h.y = y;
                h.z = z;
                h.prm = cur_prm;
                q.push_back(h);
            end
        end
    endtask

    task automatic drive(input logic en, input logic obj, input logic vtx, input logic rdy,
                         input logic [191:0] prm, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z);
        bus.iEnable   = en;
        bus.iInitObj  = obj;
        bus.iInitVtx  = vtx;
        bus.iVtxReady = rdy;
        bus.iScaleX   = prm[15:0];
        bus.iScaleY   = prm[31:16];
        bus.iScaleZ   = prm[47:32];
        bus.iTranslX  = prm[63:48];
        bus.iTranslY  = prm[79:64];
        bus.iTranslZ  = prm[95:80];
        bus.iCosRoll  = prm[111:96];
        bus.iCosPitch = prm[127:112];
        bus.iCosYaw   = prm[143:128];
        bus.iSenRoll  = prm[159:144];
        bus.iSenPitch = prm[175:160];
        bus.iSenYaw   = prm[191:176];
        bus.iVertexX  = x;
        bus.iVertexY  = y;
        bus.iVertexZ  = z;
    endtask

    // One clock: apply inputs, check pre-edge outputs, advance model and DUT.
    task automatic step(input logic en, input logic obj, input logic vtx, input logic rdy,
                        input logic [191:0] prm, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z);
        drive(en, obj, vtx, rdy, prm, x, y, z);
        #1;
        compare_all();
        model_update(en, obj, vtx, rdy, prm, x, y, z);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [191:0] rand_prm(input logic [15:0] sx);
        logic [191:0] p;
        for (int i = 0; i < 6; i++) begin
            p[32*i +: 32] = $urandom;
        end
        p[15:0] = sx;
        return p;
    endfunction

    initial begin
        logic [191:0] pa;
        logic [191:0] pb;
        logic         en, obj, vtx, rdy;
        int           rdy_pct;
        n_tests = 0;
        n_fail  = 0;
        step_no = 0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Three vertices of one object stream out in order with its parameters
        pa = rand_prm(16'h0100);
        step(1, 1, 0, 1, pa, 0, 0, 0);
        step(1, 0, 1, 1, '0, 1, 2, 3);
        step(1, 0, 1, 1, '0, 4, 5, 6);
        step(1, 0, 1, 1, '0, 7, 8, 9);
        repeat (3) step(1, 0, 0, 1, '0, 0, 0, 0);

        // Nine pushes with no drain: last one dropped, overflow sticks
        do_reset();
        step(1, 1, 0, 0, rand_prm(16'h0042), 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 1, 0, '0, 16'(i + 10), 16'(i + 20), 16'(i + 30));
        end
        step(1, 0, 0, 0, '0, 0, 0, 0);
        repeat (DEPTH + 2) step(1, 0, 0, 1, '0, 0, 0, 0);

        // Full FIFO with simultaneous push and pop keeps count, no overflow
        do_reset();
        step(1, 1, 0, 0, rand_prm(16'h0007), 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 1, 0, '0, 16'(i + 100), 16'(i + 200), 16'(i + 300));
        end
        step(1, 0, 1, 1, '0, 16'h0ABC, 16'h0DEF, 16'h0123);
        step(1, 0, 0, 0, '0, 0, 0, 0);
        repeat (DEPTH + 2) step(1, 0, 0, 1, '0, 0, 0, 0);

        // Two live objects, then a third strobe that must be rejected
        do_reset();
        pa = rand_prm(16'h0001);
        pb = rand_prm(16'h0002);
        step(1, 1, 0, 0, pa, 0, 0, 0);
        step(1, 0, 1, 0, '0, 11, 12, 13);
        step(1, 0, 1, 0, '0, 14, 15, 16);
        step(1, 1, 0, 0, pb, 0, 0, 0);
        step(1, 0, 1, 0, '0, 21, 22, 23);
        step(1, 0, 1, 0, '0, 24, 25, 26);
        step(1, 1, 0, 0, rand_prm(16'h0003), 0, 0, 0);
        repeat (6) step(1, 0, 0, 1, '0, 0, 0, 0);
        // Simultaneous object and vertex: vertex takes the new object
        step(1, 1, 1, 0, rand_prm(16'h0004), 31, 32, 33);
        repeat (2) step(1, 0, 0, 1, '0, 0, 0, 0);

        // Enable low ignores strobes but keeps draining
        do_reset();
        repeat (3) step(0, 1, 1, 1, rand_prm(16'h0055), 5, 6, 7);
        step(1, 1, 0, 0, rand_prm(16'h0066), 0, 0, 0);
        step(1, 0, 1, 0, '0, 41, 42, 43);
        step(1, 0, 1, 0, '0, 44, 45, 46);
        repeat (3) step(0, 1, 1, 1, rand_prm(16'h0077), 8, 9, 10);

        // Asynchronous reset with five entries held
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, '0, 16'(i + 50), 16'(i + 60), 16'(i + 70));
        end
        do_reset();
        step(1, 1, 0, 0, rand_prm(16'h0088), 0, 0, 0);
        step(1, 0, 1, 1, '0, 91, 92, 93);
        repeat (2) step(1, 0, 0, 1, '0, 0, 0, 0);

        // Random traffic with varying drain pressure
        for (int ph = 0; ph < 5; ph++) begin
            rdy_pct = (ph == 0) ? 10 : (ph == 1) ? 90 : (ph == 2) ? 50 : (ph == 3) ? 30 : 70;
            if (ph == 3) begin
                do_reset();
            end
            for (int i = 0; i < 400; i++) begin
                en  = ($urandom_range(0, 9) != 0);
                obj = ($urandom_range(0, 7) == 0);
                vtx = ($urandom_range(0, 2) != 0);
                rdy = ($urandom_range(0, 99) < rdy_pct);
                step(en, obj, vtx, rdy, rand_prm(16'($urandom)),
                     16'($urandom), 16'($urandom), 16'($urandom));
            end
        end
        repeat (DEPTH + 2) step(1, 0, 0, 1, '0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vtx_buffer.md
VTX_BUFFER -- requirements
Module: vtx_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, vertex FIFO depth in entries (power of two, 2..64).
REQ-002 Parameter: AW, default 3, pointer width, log2(DEPTH).
REQ-003 iClock  in  1  single clock for all state.
REQ-004 iReset  in  1  asynchronous, active-high reset.
REQ-005 iEnable  in  1  memory-manager frame-enable; when low, iInitObj/iInitVtx are ignored.
REQ-006 iInitObj  in  1  one-cycle strobe: iScale*/iTransl*/iCos*/iSen* are valid.
REQ-007 iInitVtx  in  1  one-cycle strobe: iVertexX/Y/Z are valid.
REQ-008 iScaleX/Y/Z, iTranslX/Y/Z, iCosRoll/Pitch/Yaw, iSenRoll/Pitch/Yaw  in  16 each  object parameters.
REQ-009 iVertexX/Y/Z  in  16 each  vertex coordinates.
REQ-010 iVtxReady  in  1  downstream transform stage accepts the head vertex.
REQ-011 oVtxValid  out  1  FIFO non-empty; head vertex presented.
REQ-012 oVertexX/Y/Z  out  16 each  head vertex (first-word-fall-through).
REQ-013 oScaleX/Y/Z, oTranslX/Y/Z, oCosRoll/Pitch/Yaw, oSenRoll/Pitch/Yaw  out  16 each  parameters of the object owning the head vertex.
REQ-014 oCount  out  AW+1  FIFO occupancy.
REQ-015 oFull  out  1  oCount == DEPTH.
REQ-016 oOverflow  out  1  sticky: vertex dropped.
REQ-017 oObjErr  out  1  sticky: object strobe dropped.

Function
REQ-018 Push = iEnable & iInitVtx; pop = oVtxValid & iVtxReady.
REQ-019 Each FIFO entry SHALL hold {tag(1), X, Y, Z}; tag = value of register rTag after any same-cycle iInitObj update.
REQ-020 Two parameter banks bank[0], bank[1] (12 x 16 bits each) SHALL exist; rTag selects the bank currently being filled by new vertices.
REQ-021 Accepted object strobe (iEnable & iInitObj) SHALL write all 12 parameters into bank[~rTag] and toggle rTag in the same edge.
REQ-022 Object strobe SHALL be rejected (no bank write, rTag unchanged, oObjErr <= 1) when FIFO non-empty and head tag != rTag (two objects already live).
REQ-023 Simultaneous iInitObj and iInitVtx: object processed first; the vertex SHALL carry the new tag.
REQ-024 Parameter outputs SHALL be bank[head tag] when oVtxValid = 1, else bank[rTag]; combinational from registers.
REQ-025 Latency: vertex pushed at edge N SHALL appear on oVertex*/oVtxValid after edge N (visible in cycle N+1) when FIFO was empty.
REQ-026 Pop advances read pointer at the edge; next entry visible the following cycle with no bubble.
REQ-027 Push when full and no pop: vertex dropped, state unchanged, oOverflow <= 1.
REQ-028 Push and pop same cycle when full: both performed; oCount unchanged; no overflow.
REQ-029 Pop when empty impossible (oVtxValid = 0); push and pop same cycle when empty: push only.
REQ-030 Pointers SHALL wrap modulo DEPTH; oCount SHALL never exceed DEPTH.
REQ-031 iEnable low: FIFO continues draining; no push, no bank write, no error flags.
REQ-032 oVertex* SHALL hold last head value when empty (don't-care to downstream, but stable).

Reset
REQ-033 iReset high SHALL asynchronously clear pointers, oCount, rTag, both banks, oOverflow, oObjErr to 0; oVtxValid = 0, all parameter outputs 0.
REQ-034 Reset mid-stream SHALL discard all buffered vertices and parameters; first strobe after release behaves as from power-up.
REQ-035 oOverflow and oObjErr SHALL clear only by reset.

Verification
REQ-036 Reset, iEnable=1, iInitObj with ScaleX=0x0100, then 3 iInitVtx (1,2,3),(4,5,6),(7,8,9), iVtxReady=1 -> vertices out in order, one per cycle, oScaleX=0x0100 on each.
REQ-037 iVtxReady=0, 9 pushes at DEPTH=8 -> oFull=1 after 8th, 9th dropped, oOverflow=1, oCount=8.
REQ-038 Full FIFO, push and pop same cycle -> oCount stays 8, oOverflow stays 0, new vertex at tail.
REQ-039 Obj A (ScaleX=0x0001) + 2 vtx, Obj B (ScaleX=0x0002) + 2 vtx, iVtxReady=0 then 1 -> first two outputs ScaleX=1, last two ScaleX=2; third object strobe while A entries still held -> oObjErr=1, B params unchanged.
REQ-040 iEnable=0 with strobes -> oCount=0, no flags; iReset asserted with 5 entries held -> oVtxValid=0, oCount=0 immediately, without waiting for a clock edge.
